// File: rtl/rdi_pkg.sv
// Shared RDI definitions: link-state encodings, adapter FSM states and the beat type.
package rdi_pkg;

  localparam logic [3:0] LS_NOP       = 4'h0;
  localparam logic [3:0] LS_RESET     = 4'h0;
  localparam logic [3:0] LS_ACTIVE    = 4'h1;
  localparam logic [3:0] LS_L1        = 4'h4;
  localparam logic [3:0] LS_L2        = 4'h8;
  localparam logic [3:0] LS_LINKRESET = 4'h9;
  localparam logic [3:0] LS_LINKERROR = 4'hA;
  localparam logic [3:0] LS_RETRAIN   = 4'hB;
  localparam logic [3:0] LS_DISABLED  = 4'hC;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_REQ_ACTIVE,
    ST_ACTIVE,
    ST_ERROR
  } link_st_e;

  localparam int NBYTES_DEF = 8;
  typedef logic [NBYTES_DEF*8-1:0] rdi_data_t;

endpackage

// File: rtl/rdi_tx_fifo.sv
// Synchronous transmit FIFO with flush; head is read straight from the storage registers.
module rdi_tx_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic [AW-1:0] w_waddr;

  // A push landing in the flush cycle survives as the sole entry.
  assign w_waddr = flush ? '0 : r_wptr;

  always_ff @(posedge clk) begin
    if (push) r_mem[w_waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wptr  <= push ? AW'(1) : '0;
      r_rptr  <= '0;
      r_level <= push ? (AW+1)'(1) : '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
      case ({push, pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign head  = r_mem[r_rptr];
  assign full  = (r_level == (AW+1)'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;

endmodule

// File: rtl/rdi_tx_adapter.sv
// RDI transmit adapter: buffers upstream beats and releases them only while the link is
// Active and not stalled; owns the lp_state_req FSM and the stall handshake.
module rdi_tx_adapter
  import rdi_pkg::*;
#(
  parameter int NBYTES = 8,
  parameter int DEPTH  = 8,
  parameter int CNTW   = 32
) (
  input  logic                    lclk,
  input  logic                    rst_n,
  input  logic                    link_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NBYTES*8-1:0]     in_data,
  output logic                    lp_irdy,
  output logic                    lp_valid,
  output logic [NBYTES*8-1:0]     lp_data,
  input  logic                    pl_trdy,
  output logic [3:0]              lp_state_req,
  input  logic [3:0]              pl_state_sts,
  output logic                    lp_linkerror,
  input  logic                    ctrl_linkerror,
  input  logic                    pl_stallreq,
  output logic                    lp_stallack,
  output logic                    link_active,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [CNTW-1:0]         tx_cnt
);
  link_st_e             r_state;
  link_st_e             w_next;
  logic                 r_alive;
  logic                 r_stall_hold;
  logic [CNTW-1:0]      r_tx_cnt;
  logic [NBYTES*8-1:0]  w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_offer;
  logic                 w_xfer;
  logic                 w_flush;
  logic                 w_err_in;

  assign w_err_in = ctrl_linkerror | (pl_state_sts == LS_LINKERROR);
  assign w_offer  = (r_state == ST_ACTIVE) & !w_empty & !r_stall_hold;
  assign w_xfer   = w_offer & pl_trdy;
  assign w_push   = in_valid & in_ready;
  assign w_flush  = (w_next == ST_ERROR) & (r_state != ST_ERROR);
  assign in_ready = r_alive & !w_full;

  rdi_tx_fifo #(
    .DW    (NBYTES*8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (lclk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_xfer),
    .flush (w_flush),
    .wdata (in_data),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  always_ff @(posedge lclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RESET;
      r_alive      <= 1'b0;
      r_stall_hold <= 1'b0;
      r_tx_cnt     <= '0;
    end else begin
      r_state <= w_next;
      r_alive <= 1'b1;
      if (w_xfer) r_tx_cnt <= r_tx_cnt + 1'b1;
      // Stall is granted only once no beat is left hanging on the channel.
      if (!pl_stallreq)              r_stall_hold <= 1'b0;
      else if (!w_offer || w_xfer)   r_stall_hold <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_err_in) begin
      w_next = ST_ERROR;
    end else if (r_state == ST_ERROR) begin
      if (pl_state_sts == LS_RESET) w_next = ST_RESET;
    end else if (!link_en) begin
      w_next = ST_RESET;
    end else begin
      case (r_state)
        ST_RESET:      w_next = ST_REQ_ACTIVE;
        ST_REQ_ACTIVE: if (pl_state_sts == LS_ACTIVE) w_next = ST_ACTIVE;
        ST_ACTIVE:     if (pl_state_sts != LS_ACTIVE) w_next = ST_REQ_ACTIVE;
        default:       w_next = r_state;
      endcase
    end
  end

  always_comb begin
    lp_state_req = LS_NOP;
    lp_linkerror = 1'b0;
    link_active  = 1'b0;
    case (r_state)
      ST_REQ_ACTIVE: lp_state_req = LS_ACTIVE;
      ST_ACTIVE: begin
        lp_state_req = LS_ACTIVE;
        link_active  = 1'b1;
      end
      ST_ERROR:      lp_linkerror = 1'b1;
      default:       lp_state_req = LS_NOP;
    endcase
    lp_irdy  = w_offer;
    lp_valid = w_offer;
    lp_data  = w_offer ? w_head : '0;
  end

  assign lp_stallack = r_stall_hold;
  assign tx_cnt      = r_tx_cnt;

endmodule

// File: tb/tb_rdi_tx_adapter.sv
// Bench for rdi_tx_adapter: FSM vector table plus hand sequences, with a beat scoreboard.
module tb_rdi_tx_adapter;
  localparam int NB = 8;
  localparam int DP = 8;
  localparam int CW = 4;

  logic          lclk;
  logic          rst_n;
  logic          link_en;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          lp_irdy;
  logic          lp_valid;
  logic [63:0]   lp_data;
  logic          pl_trdy;
  logic [3:0]    lp_state_req;
  logic [3:0]    pl_state_sts;
  logic          lp_linkerror;
  logic          ctrl_linkerror;
  logic          pl_stallreq;
  logic          lp_stallack;
  logic          link_active;
  logic [3:0]    fifo_level;
  logic [CW-1:0] tx_cnt;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  rdi_tx_adapter #(.NBYTES(NB), .DEPTH(DP), .CNTW(CW)) dut (
    .lclk           (lclk),
    .rst_n          (rst_n),
    .link_en        (link_en),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .lp_irdy        (lp_irdy),
    .lp_valid       (lp_valid),
    .lp_data        (lp_data),
    .pl_trdy        (pl_trdy),
    .lp_state_req   (lp_state_req),
    .pl_state_sts   (pl_state_sts),
    .lp_linkerror   (lp_linkerror),
    .ctrl_linkerror (ctrl_linkerror),
    .pl_stallreq    (pl_stallreq),
    .lp_stallack    (lp_stallack),
    .link_active    (link_active),
    .fifo_level     (fifo_level),
    .tx_cnt         (tx_cnt)
  );

  initial lclk = 1'b0;
  always #5 lclk = ~lclk;

  initial begin
    #500000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge lclk);
    #1;
  endtask

  task automatic push(input logic [63:0] d);
    in_data  = d;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !in_ready; k++) tick();
    if (!in_ready) chk("push_ready", {95'd0, in_ready}, 96'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_level(input logic [3:0] n, input string nm);
    for (int k = 0; k < 64; k++) begin
      if (fifo_level == n) break;
      tick();
    end
    chk(nm, {92'd0, fifo_level}, {92'd0, n});
  endtask

  // Scoreboard: beats enter on upstream acceptance, leave on RDI transfer.
  always @(negedge lclk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (lp_irdy && lp_valid && pl_trdy) begin
        if (exp_q.size() == 0) chk("beat_unexpected", {32'd0, lp_data}, 96'd0);
        else chk("beat", {32'd0, lp_data}, {32'd0, exp_q.pop_front()});
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  typedef struct {
    logic       en;
    logic [3:0] sts;
    logic       err;
    logic       sreq;
    logic [7:0] exp;  // {lp_state_req, link_active, lp_linkerror, lp_stallack, lp_irdy}
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, 8'h10};
    tbl[1]  = '{1'b1, 4'h0, 1'b0, 1'b0, 8'h10};
    tbl[2]  = '{1'b1, 4'h1, 1'b0, 1'b0, 8'h18};
    tbl[3]  = '{1'b1, 4'h1, 1'b0, 1'b1, 8'h1A};
    tbl[4]  = '{1'b1, 4'h1, 1'b0, 1'b0, 8'h18};
    tbl[5]  = '{1'b1, 4'hB, 1'b0, 1'b0, 8'h10};
    tbl[6]  = '{1'b0, 4'h1, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 4'hA, 1'b0, 1'b0, 8'h04};
    tbl[8]  = '{1'b1, 4'h0, 1'b1, 1'b0, 8'h04};
    tbl[9]  = '{1'b1, 4'h1, 1'b0, 1'b0, 8'h04};
    tbl[10] = '{1'b1, 4'h0, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b1, 4'h0, 1'b0, 1'b1, 8'h12};
    tbl[12] = '{1'b1, 4'h0, 1'b0, 1'b0, 8'h10};
    tbl[13] = '{1'b0, 4'h0, 1'b0, 1'b0, 8'h00};

    rst_n = 1'b0; link_en = 1'b0; in_valid = 1'b0; in_data = '0; pl_trdy = 1'b0;
    pl_state_sts = 4'h0; ctrl_linkerror = 1'b0; pl_stallreq = 1'b0;

    // Reset state
    tick(); tick();
    chk("reset_outputs", {14'd0, in_ready, lp_irdy, lp_valid, lp_data, lp_state_req,
        lp_linkerror, lp_stallack, link_active, fifo_level, tx_cnt}, 96'd0);
    rst_n = 1'b1;
    chk("in_ready_before_edge", {95'd0, in_ready}, 96'd0);
    tick();
    chk("in_ready_after_reset", {95'd0, in_ready}, 96'd1);

    // FSM / stall vector table with an empty FIFO
    for (int i = 0; i < 14; i++) begin
      link_en = tbl[i].en; pl_state_sts = tbl[i].sts;
      ctrl_linkerror = tbl[i].err; pl_stallreq = tbl[i].sreq;
      tick();
      chk($sformatf("fsm_row%0d", i),
          {88'd0, lp_state_req, link_active, lp_linkerror, lp_stallack, lp_irdy},
          {88'd0, tbl[i].exp});
    end

    // Bring-up with four preloaded beats
    for (int i = 0; i < 4; i++) push(64'hA0 + 64'(i));
    chk("preload_level", {92'd0, fifo_level}, 96'd4);
    chk("preload_no_irdy", {95'd0, lp_irdy}, 96'd0);
    pl_trdy = 1'b1; link_en = 1'b1; pl_state_sts = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bringup_req%0d", i), {91'd0, lp_state_req, link_active}, {91'd0, 4'h1, 1'b0});
    end
    pl_state_sts = 4'h1;
    tick();
    chk("bringup_active", {31'd0, link_active, lp_irdy, lp_data}, {31'd0, 1'b1, 1'b1, 64'hA0});
    wait_level(4'd0, "bringup_drain");
    chk("bringup_tx_cnt", {92'd0, tx_cnt}, 96'd4);

    // Backpressure: beat held stable, then fill the FIFO
    pl_trdy = 1'b0;
    push(64'h55);
    chk("first_word_latency", {95'd0, lp_irdy}, 96'd1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp_hold%0d", i), {31'd0, lp_irdy, lp_valid, lp_data}, {31'd0, 2'b11, 64'h55});
      tick();
    end
    for (int i = 0; i < 7; i++) push(64'h10 + 64'(i));
    chk("full_level", {92'd0, fifo_level}, 96'd8);
    chk("full_in_ready", {95'd0, in_ready}, 96'd0);
    in_data = 64'h66; in_valid = 1'b1;
    tick(); tick();
    chk("full_no_accept", {92'd0, fifo_level}, 96'd8);
    pl_trdy = 1'b1;
    tick();
    pl_trdy = 1'b0;
    chk("full_pop_no_bypass", {92'd0, fifo_level}, 96'd7);
    chk("in_ready_after_pop", {95'd0, in_ready}, 96'd1);
    tick();
    in_valid = 1'b0;
    chk("refill_level", {92'd0, fifo_level}, 96'd8);

    // Stall request while a beat is pending
    pl_stallreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_pending%0d", i), {30'd0, lp_stallack, lp_irdy, lp_data},
          {30'd0, 2'b01, 64'h10});
    end
    pl_trdy = 1'b1;
    tick();
    chk("stall_ack", {94'd0, lp_stallack, lp_irdy}, {94'd0, 2'b10});
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("stall_held%0d", i), {90'd0, lp_stallack, lp_irdy, fifo_level},
          {90'd0, 2'b10, 4'd7});
    end
    pl_stallreq = 1'b0;
    tick();
    chk("stall_release", {94'd0, lp_stallack, lp_irdy}, {94'd0, 2'b01});

    // Retrain with three beats queued
    wait_level(4'd3, "retrain_prefill");
    pl_trdy = 1'b0; pl_state_sts = 4'hB;
    tick();
    chk("retrain_drop", {87'd0, lp_irdy, link_active, lp_state_req, fifo_level},
        {87'd0, 1'b0, 1'b0, 4'h1, 4'd3});
    pl_state_sts = 4'h1;
    tick();
    chk("retrain_resume", {91'd0, lp_irdy, fifo_level}, {91'd0, 1'b1, 4'd3});
    pl_trdy = 1'b1;
    wait_level(4'd0, "retrain_drain");
    chk("retrain_tx_cnt", {92'd0, tx_cnt}, 96'd13);
    chk("scoreboard_empty", 96'(exp_q.size()), 96'd0);

    // Link error flush
    pl_trdy = 1'b0;
    for (int i = 0; i < 5; i++) push(64'h20 + 64'(i));
    chk("err_prefill", {92'd0, fifo_level}, 96'd5);
    ctrl_linkerror = 1'b1;
    tick();
    ctrl_linkerror = 1'b0;
    exp_q.delete();
    chk("err_entry", {86'd0, lp_linkerror, lp_irdy, lp_state_req, fifo_level},
        {86'd0, 1'b1, 1'b0, 4'h0, 4'd0});
    tick();
    chk("err_stays_sts_active", {95'd0, lp_linkerror}, 96'd1);
    pl_state_sts = 4'h0;
    tick();
    chk("err_exit", {90'd0, lp_linkerror, link_active, lp_state_req}, {90'd0, 2'b00, 4'h0});
    chk("err_tx_cnt", {92'd0, tx_cnt}, 96'd13);

    // Counter wrap after a fresh reset
    rst_n = 1'b0;
    #1;
    chk("reset2_outputs", {14'd0, in_ready, lp_irdy, lp_valid, lp_data, lp_state_req,
        lp_linkerror, lp_stallack, link_active, fifo_level, tx_cnt}, 96'd0);
    tick();
    rst_n = 1'b1;
    link_en = 1'b1; pl_state_sts = 4'h1;
    tick(); tick();
    chk("wrap_active", {95'd0, link_active}, 96'd1);
    pl_trdy = 1'b1;
    for (int i = 0; i < 17; i++) push(64'h30 + 64'(i));
    wait_level(4'd0, "wrap_drain");
    chk("wrap_tx_cnt", {92'd0, tx_cnt}, 96'd1);

    // Asynchronous reset with a beat on the channel
    in_data = 64'h77; in_valid = 1'b1;
    tick();
    chk("midxfer_irdy", {95'd0, lp_irdy}, 96'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {14'd0, in_ready, lp_irdy, lp_valid, lp_data, lp_state_req,
        lp_linkerror, lp_stallack, link_active, fifo_level, tx_cnt}, 96'd0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
